// File: rtl/rob_ring_pkg.sv
// rob_ring shared definitions: exception encoding, default
// widths and a small helper for select-index sizing.
package rob_ring_pkg;

  localparam int ROB_ADDR     = 4;
  localparam int DATA_W       = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int EXC_W        = 4;
  localparam int PC_W         = 32;
  localparam int WB_PORTS_DEF = 2;

  localparam logic [EXC_W-1:0] EXC_TYPE_NULL = '0;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rob_ring_if.sv
// rob_ring channel bundle: alloc, writeback, lookup and commit.
// master drives the ROB (stage glue), slave is the ROB itself.
interface rob_ring_if #(
  parameter int ADDR_WIDTH     = rob_ring_pkg::ROB_ADDR,
  parameter int DATA_WIDTH     = rob_ring_pkg::DATA_W,
  parameter int REG_ADDR_WIDTH = rob_ring_pkg::REG_ADDR_W,
  parameter int EXC_WIDTH      = rob_ring_pkg::EXC_W,
  parameter int WB_PORTS       = rob_ring_pkg::WB_PORTS_DEF
);

  logic                            flush;
  logic                            alloc_en;
  logic                            alloc_ready;
  logic [ADDR_WIDTH-1:0]           alloc_id;
  logic                            alloc_reg_write_en;
  logic [REG_ADDR_WIDTH-1:0]       alloc_reg_write_addr;
  logic [EXC_WIDTH-1:0]            alloc_exc_type;
  logic                            alloc_is_delayslot;
  logic [31:0]                     alloc_pc;

  logic [WB_PORTS-1:0]             wb_en;
  logic [WB_PORTS*ADDR_WIDTH-1:0]  wb_id;
  logic [WB_PORTS*DATA_WIDTH-1:0]  wb_data;
  logic [WB_PORTS*EXC_WIDTH-1:0]   wb_exc_type;

  logic [ADDR_WIDTH-1:0]           rd_id_1;
  logic [ADDR_WIDTH-1:0]           rd_id_2;
  logic                            rd_done_1;
  logic                            rd_done_2;
  logic [DATA_WIDTH-1:0]           rd_data_1;
  logic [DATA_WIDTH-1:0]           rd_data_2;

  logic                            commit_valid;
  logic                            commit_ready;
  logic [ADDR_WIDTH-1:0]           commit_id;
  logic                            commit_reg_write_en;
  logic [REG_ADDR_WIDTH-1:0]       commit_reg_write_addr;
  logic [DATA_WIDTH-1:0]           commit_reg_write_data;
  logic [EXC_WIDTH-1:0]            commit_exc_type;
  logic                            commit_is_delayslot;
  logic [31:0]                     commit_pc;

  modport master (
    output flush, alloc_en, alloc_reg_write_en,
    output alloc_reg_write_addr, alloc_exc_type,
    output alloc_is_delayslot, alloc_pc,
    output wb_en, wb_id, wb_data, wb_exc_type,
    output rd_id_1, rd_id_2, commit_ready,
    input  alloc_ready, alloc_id,
    input  rd_done_1, rd_done_2, rd_data_1, rd_data_2,
    input  commit_valid, commit_id, commit_reg_write_en,
    input  commit_reg_write_addr, commit_reg_write_data,
    input  commit_exc_type, commit_is_delayslot, commit_pc
  );

  modport slave (
    input  flush, alloc_en, alloc_reg_write_en,
    input  alloc_reg_write_addr, alloc_exc_type,
    input  alloc_is_delayslot, alloc_pc,
    input  wb_en, wb_id, wb_data, wb_exc_type,
    input  rd_id_1, rd_id_2, commit_ready,
    output alloc_ready, alloc_id,
    output rd_done_1, rd_done_2, rd_data_1, rd_data_2,
    output commit_valid, commit_id, commit_reg_write_en,
    output commit_reg_write_addr, commit_reg_write_data,
    output commit_exc_type, commit_is_delayslot, commit_pc
  );

endinterface

// File: rtl/rob_ring_wb_select.sv
// Writeback port matcher: finds the lowest-indexed enabled
// writeback port whose target ID equals the query ID.
module rob_ring_wb_select
  import rob_ring_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_ADDR,
  parameter int WB_PORTS   = WB_PORTS_DEF,
  parameter int PW         = idx_w(WB_PORTS)
) (
  input  logic [ADDR_WIDTH-1:0]          i_qid,
  input  logic [WB_PORTS-1:0]            i_wb_en,
  input  logic [WB_PORTS*ADDR_WIDTH-1:0] i_wb_id,
  output logic                           o_hit,
  output logic [PW-1:0]                  o_port
);

  // scan high to low so the lowest matching port lands last
  always_comb begin
    o_hit  = 1'b0;
    o_port = '0;
    for (int k = WB_PORTS - 1; k >= 0; k--) begin
      if (i_wb_en[k] &&
          i_wb_id[k*ADDR_WIDTH +: ADDR_WIDTH] == i_qid) begin
        o_hit  = 1'b1;
        o_port = PW'(k);
      end
    end
  end

endmodule

// File: rtl/rob_ring.sv
// Reorder-buffer ring: in-order allocate/commit, out-of-order
// multi-port writeback, two bypassed operand lookup ports.
module rob_ring
  import rob_ring_pkg::*;
#(
  parameter int ADDR_WIDTH     = ROB_ADDR,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int EXC_WIDTH      = EXC_W,
  parameter int WB_PORTS       = WB_PORTS_DEF
) (
  input logic      clk,
  input logic      rst,
  rob_ring_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = idx_w(WB_PORTS);
  localparam logic [EXC_WIDTH-1:0] XNULL =
    EXC_WIDTH'(EXC_TYPE_NULL);

  typedef logic [ADDR_WIDTH-1:0] id_t;

  logic [ADDR_WIDTH:0]       r_head, r_tail;
  logic [DEPTH-1:0]          r_busy, r_done;
  logic [DEPTH-1:0]          r_rwe, r_ds;
  logic [DATA_WIDTH-1:0]     r_data  [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] r_raddr [DEPTH];
  logic [EXC_WIDTH-1:0]      r_exc   [DEPTH];
  logic [31:0]               r_pc    [DEPTH];

  logic [DATA_WIDTH-1:0] w_wb_data [WB_PORTS];
  logic [EXC_WIDTH-1:0]  w_wb_exc  [WB_PORTS];
  logic [DEPTH-1:0]      w_hit;
  logic [PW-1:0]         w_port    [DEPTH];
  logic [1:0]            w_rd_hit;
  logic [PW-1:0]         w_rd_port [2];

  id_t  w_h, w_t;
  logic w_full, w_empty, w_alloc, w_cvalid, w_commit;

  assign w_h      = r_head[ADDR_WIDTH-1:0];
  assign w_t      = r_tail[ADDR_WIDTH-1:0];
  assign w_full   = (w_h == w_t) &&
                    (r_head[ADDR_WIDTH] != r_tail[ADDR_WIDTH]);
  assign w_empty  = (r_head == r_tail);
  assign w_alloc  = bus.alloc_en && !w_full;
  assign w_cvalid = r_busy[w_h] && r_done[w_h];
  assign w_commit = w_cvalid && bus.commit_ready;

  for (genvar k = 0; k < WB_PORTS; k++) begin : g_port
    assign w_wb_data[k] =
      bus.wb_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_wb_exc[k] =
      bus.wb_exc_type[k*EXC_WIDTH +: EXC_WIDTH];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rob_ring_wb_select #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .WB_PORTS  (WB_PORTS)
    ) u_sel (
      .i_qid  (id_t'(i)),
      .i_wb_en(bus.wb_en),
      .i_wb_id(bus.wb_id),
      .o_hit  (w_hit[i]),
      .o_port (w_port[i])
    );
  end

  rob_ring_wb_select #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WB_PORTS  (WB_PORTS)
  ) u_rd1 (
    .i_qid  (bus.rd_id_1),
    .i_wb_en(bus.wb_en),
    .i_wb_id(bus.wb_id),
    .o_hit  (w_rd_hit[0]),
    .o_port (w_rd_port[0])
  );

  rob_ring_wb_select #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WB_PORTS  (WB_PORTS)
  ) u_rd2 (
    .i_qid  (bus.rd_id_2),
    .i_wb_en(bus.wb_en),
    .i_wb_id(bus.wb_id),
    .o_hit  (w_rd_hit[1]),
    .o_port (w_rd_port[1])
  );

  // an allocated slot is never busy, so alloc and wb never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_busy <= '0;
      r_done <= '0;
      r_rwe  <= '0;
      r_ds   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]  <= '0;
        r_raddr[i] <= '0;
        r_exc[i]   <= '0;
        r_pc[i]    <= '0;
      end
    end else if (bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_busy <= '0;
      r_done <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hit[i] && r_busy[i]) begin
          r_done[i] <= 1'b1;
          r_data[i] <= w_wb_data[w_port[i]];
          if (w_wb_exc[w_port[i]] != XNULL)
            r_exc[i] <= w_wb_exc[w_port[i]];
        end
      end
      if (w_commit) begin
        r_busy[w_h] <= 1'b0;
        r_head      <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_busy[w_t]  <= 1'b1;
        r_done[w_t]  <= 1'b0;
        r_data[w_t]  <= '0;
        r_rwe[w_t]   <= bus.alloc_reg_write_en;
        r_raddr[w_t] <= bus.alloc_reg_write_addr;
        r_exc[w_t]   <= bus.alloc_exc_type;
        r_ds[w_t]    <= bus.alloc_is_delayslot;
        r_pc[w_t]    <= bus.alloc_pc;
        r_tail       <= r_tail + 1'b1;
      end
    end
  end

  assign bus.alloc_ready = !w_full;
  assign bus.alloc_id    = w_t;

  assign bus.rd_done_1 = r_busy[bus.rd_id_1] &&
    (w_rd_hit[0] || r_done[bus.rd_id_1]);
  assign bus.rd_data_1 =
    (r_busy[bus.rd_id_1] && w_rd_hit[0]) ?
    w_wb_data[w_rd_port[0]] : r_data[bus.rd_id_1];

  assign bus.rd_done_2 = r_busy[bus.rd_id_2] &&
    (w_rd_hit[1] || r_done[bus.rd_id_2]);
  assign bus.rd_data_2 =
    (r_busy[bus.rd_id_2] && w_rd_hit[1]) ?
    w_wb_data[w_rd_port[1]] : r_data[bus.rd_id_2];

  assign bus.commit_valid = w_cvalid;
  assign bus.commit_id    = w_empty ? '0 : w_h;
  assign bus.commit_reg_write_en =
    w_empty ? 1'b0 : r_rwe[w_h];
  assign bus.commit_reg_write_addr =
    w_empty ? '0 : r_raddr[w_h];
  assign bus.commit_reg_write_data =
    w_empty ? '0 : r_data[w_h];
  assign bus.commit_exc_type =
    w_empty ? '0 : r_exc[w_h];
  assign bus.commit_is_delayslot =
    w_empty ? 1'b0 : r_ds[w_h];
  assign bus.commit_pc = w_empty ? '0 : r_pc[w_h];

endmodule
